// File: rtl/gate_exerciser.sv
// Purpose: sweeps the four input combinations of an external 2-input gate and checks its output against TRUTH_TABLE.
// Latency: each vector is held SETTLE_CYCLES cycles; a run lasts 4*SETTLE_CYCLES*PASSES cycles, then done pulses for one cycle.
// Backpressure: none; start is only accepted in IDLE and is dropped in RUN/DONE, with no queuing.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   start               begin a run (sampled only when idle)
//   gate_a, gate_b      registered drives to the gate under test
//   gate_c              gate output under test, assumed synchronous to clk
//   busy, done          run in progress / one-cycle completion pulse
//   pass                no mismatches in the last run (valid from done until next start)
//   err_count           mismatch count, saturating at 255
//   fail_vec            bit i set if vector i = {a,b} mismatched in any sweep
module gate_exerciser #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] TRUTH_TABLE   = 4'b1110,
    parameter int         PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

    state_t     state, state_n;
    logic [1:0] vec, vec_n;             // {gate_a, gate_b}
    logic [7:0] settle_cnt, settle_cnt_n;
    logic [7:0] pass_cnt, pass_cnt_n;
    logic       busy_n, done_n, pass_n;
    logic [7:0] err_count_n;
    logic [3:0] fail_vec_n;
    logic       sample;
    logic       mismatch;

    assign gate_a = vec[1];
    assign gate_b = vec[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= 2'b00;
            settle_cnt <= 8'd0;
            pass_cnt   <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 8'd0;
            fail_vec   <= 4'd0;
        end else begin
            state      <= state_n;
            vec        <= vec_n;
            settle_cnt <= settle_cnt_n;
            pass_cnt   <= pass_cnt_n;
            busy       <= busy_n;
            done       <= done_n;
            pass       <= pass_n;
            err_count  <= err_count_n;
            fail_vec   <= fail_vec_n;
        end
    end

    always_comb begin
        state_n      = state;
        vec_n        = vec;
        settle_cnt_n = settle_cnt;
        pass_cnt_n   = pass_cnt;
        busy_n       = busy;
        done_n       = 1'b0;
        pass_n       = pass;
        err_count_n  = err_count;
        fail_vec_n   = fail_vec;
        sample       = (settle_cnt == SETTLE_LAST);
        mismatch     = (gate_c != TRUTH_TABLE[vec]);

        case (state)
            IDLE: begin
                if (start) begin
                    state_n      = RUN;
                    busy_n       = 1'b1;
                    vec_n        = 2'b00;
                    err_count_n  = 8'd0;
                    fail_vec_n   = 4'd0;
                    pass_n       = 1'b0;
                    settle_cnt_n = 8'd0;
                    pass_cnt_n   = 8'd0;
                end
            end
            RUN: begin
                if (!sample) begin
                    settle_cnt_n = settle_cnt + 8'd1;
                end else begin
                    settle_cnt_n = 8'd0;
                    vec_n        = vec + 2'd1;
                    if (mismatch) begin
                        if (err_count != 8'hFF) begin
                            err_count_n = err_count + 8'd1;
                        end
                        fail_vec_n[vec] = 1'b1;
                    end
                    if (vec == 2'b11) begin
                        pass_cnt_n = pass_cnt + 8'd1;
                        if (pass_cnt == PASS_LAST) begin
                            state_n    = DONE;
                            busy_n     = 1'b0;
                            done_n     = 1'b1;
                            vec_n      = 2'b00;
                            pass_cnt_n = 8'd0;
                            // fail_vec still lacks the final sample, so fold it in here.
                            pass_n     = (fail_vec == 4'd0) && !mismatch;
                        end
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: six instances with different parameter sets share one clock and reset;
// each instance gets its own gate model (OR, stuck-0, stuck-1, AND, or OR delayed by two register stages).
// A run task walks a run cycle by cycle against a sequence model and then checks the final results.
module tb_gate_exerciser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] start;
    logic [5:0] ga, gb, gc, busy, done, pass;
    logic [7:0] ec [6];
    logic [3:0] fv [6];
    logic [2:0] mode [6];
    logic [5:0] d1 = '0, d2 = '0;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] M_OR = 3'd0, M_S0 = 3'd1, M_S1 = 3'd2, M_AND = 3'd3, M_DLY = 3'd4;

    always #5 clk = ~clk;

    gate_exerciser u0 (.clk(clk), .rst_n(rst_n), .start(start[0]), .gate_a(ga[0]), .gate_b(gb[0]), .gate_c(gc[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(ec[0]), .fail_vec(fv[0]));
    gate_exerciser #(.PASSES(3)) u1 (.clk(clk), .rst_n(rst_n), .start(start[1]), .gate_a(ga[1]), .gate_b(gb[1]), .gate_c(gc[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(ec[1]), .fail_vec(fv[1]));
    gate_exerciser #(.TRUTH_TABLE(4'b1000)) u2 (.clk(clk), .rst_n(rst_n), .start(start[2]), .gate_a(ga[2]), .gate_b(gb[2]), .gate_c(gc[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(ec[2]), .fail_vec(fv[2]));
    gate_exerciser #(.SETTLE_CYCLES(1)) u3 (.clk(clk), .rst_n(rst_n), .start(start[3]), .gate_a(ga[3]), .gate_b(gb[3]), .gate_c(gc[3]),
        .busy(busy[3]), .done(done[3]), .pass(pass[3]), .err_count(ec[3]), .fail_vec(fv[3]));
    gate_exerciser #(.SETTLE_CYCLES(3)) u4 (.clk(clk), .rst_n(rst_n), .start(start[4]), .gate_a(ga[4]), .gate_b(gb[4]), .gate_c(gc[4]),
        .busy(busy[4]), .done(done[4]), .pass(pass[4]), .err_count(ec[4]), .fail_vec(fv[4]));
    gate_exerciser #(.PASSES(100)) u5 (.clk(clk), .rst_n(rst_n), .start(start[5]), .gate_a(ga[5]), .gate_b(gb[5]), .gate_c(gc[5]),
        .busy(busy[5]), .done(done[5]), .pass(pass[5]), .err_count(ec[5]), .fail_vec(fv[5]));

    // Gates under test: a two-stage registered OR plus the combinational variants.
    always_ff @(posedge clk) begin
        d1 <= ga | gb;
        d2 <= d1;
    end

    always_comb begin
        gc = '0;
        for (int g = 0; g < 6; g++) begin
            case (mode[g])
                M_OR:    gc[g] = ga[g] | gb[g];
                M_S0:    gc[g] = 1'b0;
                M_S1:    gc[g] = 1'b1;
                M_AND:   gc[g] = ga[g] & gb[g];
                default: gc[g] = d2[g];
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Vector applied during run cycle k; before the run the drives sit at 00.
    function automatic int vec_at(input int k, input int s);
        if (k < 0) return 0;
        return (k / s) % 4;
    endfunction

    // Gate output seen during run cycle k for a given gate model.
    function automatic logic gate_model(input logic [2:0] md, input int k, input int s);
        int v;
        v = vec_at(k, s);
        case (md)
            M_OR:    return v != 0;
            M_S0:    return 1'b0;
            M_S1:    return 1'b1;
            M_AND:   return v == 3;
            default: return vec_at(k - 2, s) != 0;
        endcase
    endfunction

    // Runs instance i from a negedge and returns at a negedge, two cycles after done.
    // rep re-asserts start during RUN (cycle 3) and during DONE; both must be ignored.
    task automatic run(input int i, input int s, input int p, input logic [3:0] tt, input logic [2:0] md, input bit rep);
        int       e = 0;
        int       v;
        logic [3:0] f = 4'd0;
        mode[i]  = md;
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        for (int k = 0; k < 4 * s * p; k++) begin
            v = vec_at(k, s);
            chk("run_busy", busy[i], 1);
            chk("run_done", done[i], 0);
            chk("run_vec", {ga[i], gb[i]}, v);
            if (rep && k == 3) start[i] = 1'b1;
            if (rep && k == 4) start[i] = 1'b0;
            if (k % s == s - 1 && gate_model(md, k, s) != tt[v]) begin
                if (e < 255) e++;
                f[v] = 1'b1;
            end
            @(negedge clk);
        end
        chk("end_busy", busy[i], 0);
        chk("end_done", done[i], 1);
        chk("end_vec", {ga[i], gb[i]}, 0);
        chk("end_err", ec[i], e);
        chk("end_fail", fv[i], f);
        chk("end_pass", pass[i], (f == 4'd0) ? 1 : 0);
        if (rep) start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        chk("post_done", done[i], 0);
        chk("post_busy", busy[i], 0);
        @(negedge clk);
        chk("idle_busy", busy[i], 0);
        chk("idle_done", done[i], 0);
        chk("hold_err", ec[i], e);
        chk("hold_fail", fv[i], f);
    endtask

    initial begin
        int done_seen;
        rst_n = 1'b0;
        start = '0;
        for (int g = 0; g < 6; g++) mode[g] = M_OR;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_pass", pass[0], 0);
        chk("rst_err", ec[0], 0);
        chk("rst_fail", fv[0], 0);
        chk("rst_vec", {ga[0], gb[0]}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ideal OR.
        run(0, 2, 1, 4'b1110, M_OR, 1'b0);
        chk("or_pass", pass[0], 1);
        chk("or_err", ec[0], 0);
        chk("or_fail", fv[0], 0);

        // Stuck-at faults.
        run(0, 2, 1, 4'b1110, M_S0, 1'b0);
        chk("s0_pass", pass[0], 0);
        chk("s0_err", ec[0], 3);
        chk("s0_fail", fv[0], 4'b1110);
        run(0, 2, 1, 4'b1110, M_S1, 1'b0);
        chk("s1_err", ec[0], 1);
        chk("s1_fail", fv[0], 4'b0001);

        // AND gate against OR and AND tables.
        run(0, 2, 1, 4'b1110, M_AND, 1'b0);
        chk("and_err", ec[0], 2);
        chk("and_fail", fv[0], 4'b0110);
        run(1, 2, 3, 4'b1110, M_AND, 1'b0);
        chk("and3_err", ec[1], 6);
        chk("and3_fail", fv[1], 4'b0110);
        run(2, 2, 1, 4'b1000, M_AND, 1'b0);
        chk("andtt_pass", pass[2], 1);

        // Two-stage delayed OR: too short a settle fails, long enough passes.
        run(3, 1, 1, 4'b1110, M_DLY, 1'b0);
        chk("dly1_pass", pass[3], 0);
        chk("dly1_err", ec[3], 2);
        chk("dly1_fail", fv[3], 4'b0110);
        run(4, 3, 1, 4'b1110, M_DLY, 1'b0);
        chk("dly3_pass", pass[4], 1);
        chk("dly3_err", ec[4], 0);

        // Start re-pulsed mid-run and in DONE.
        run(0, 2, 1, 4'b1110, M_OR, 1'b1);
        chk("rep_pass", pass[0], 1);

        // Reset at cycle 5 of a run aborts it with no done pulse.
        mode[0]  = M_S0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy[0], 0);
        chk("abort_done", done[0], 0);
        chk("abort_vec", {ga[0], gb[0]}, 0);
        chk("abort_err", ec[0], 0);
        chk("abort_fail", fv[0], 0);
        chk("abort_pass", pass[0], 0);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done[0] || busy[0]) done_seen++;
        end
        chk("abort_quiet", done_seen, 0);
        run(0, 2, 1, 4'b1110, M_OR, 1'b0);
        chk("fresh_pass", pass[0], 1);

        // Error count saturation over 100 sweeps.
        run(5, 2, 100, 4'b1110, M_S0, 1'b0);
        chk("sat_err", ec[5], 255);
        chk("sat_fail", fv[5], 4'b1110);
        chk("sat_pass", pass[5], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
